mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the IF stage (port I) and the MEM stage (port D) of the 5-stage MIPS pipeline.
- Serialises accesses over a req/ack memory handshake and returns read data to each port.
- Generates per-port stall levels that feed the hazard unit's StallF/StallD/FlushE logic.
- Bounds I-port starvation and times out on a hung memory.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port I/D memory between the fetch port and the MEM-stage port.
// Requests are serialised over a req/ack handshake, with a D-run starvation bound and an ack timeout.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_D_RUN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    localparam int RUN_W = $clog2(MAX_D_RUN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_D_RUN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} stateType;

    stateType          state, stateNext;
    logic              grantI, grantD, finish, abort;
    logic [RUN_W-1:0]  runCnt;
    logic [TMO_W-1:0]  tmoCnt;
    logic              memReq, memWe, iDone, dDone, errQ;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata, iRdata, dRdata;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // I only overtakes D once D has had MAX_D_RUN grants in a row against a waiting I
                if (d_req && (!i_req || runCnt < RUN_MAX)) begin
                    grantD    = 1'b1;
                    stateNext = BUSY_D;
                end else if (i_req) begin
                    grantI    = 1'b1;
                    stateNext = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    finish    = 1'b1;
                    stateNext = IDLE;
                end else if (tmoCnt == TMO_LAST) begin
                    abort     = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            iRdata   <= '0;
            dRdata   <= '0;
            iDone    <= 1'b0;
            dDone    <= 1'b0;
            errQ     <= 1'b0;
            runCnt   <= '0;
            tmoCnt   <= '0;
        end else begin
            iDone <= 1'b0;
            dDone <= 1'b0;
            errQ  <= 1'b0;
            if (grantD) begin
                memReq   <= 1'b1;
                memWe    <= d_we;
                memAddr  <= d_addr;
                memWdata <= d_wdata;
                tmoCnt   <= '0;
                if (!i_req)                runCnt <= '0;
                else if (runCnt != RUN_MAX) runCnt <= runCnt + 1'b1;
            end
            if (grantI) begin
                memReq   <= 1'b1;
                memWe    <= 1'b0;
                memAddr  <= i_addr;
                memWdata <= '0;
                tmoCnt   <= '0;
                runCnt   <= '0;
            end
            if (finish || abort) begin
                memReq <= 1'b0;
                tmoCnt <= '0;
                iDone  <= (state == BUSY_I);
                dDone  <= (state == BUSY_D);
                errQ   <= abort;
            end else if (state != IDLE) begin
                tmoCnt <= tmoCnt + 1'b1;
            end
            // stores and aborted accesses leave the read-data registers untouched
            if (finish && state == BUSY_I)           iRdata <= mem_rdata;
            if (finish && state == BUSY_D && !memWe) dRdata <= mem_rdata;
        end
    end

    assign mem_req   = memReq;
    assign mem_we    = memWe;
    assign mem_addr  = memAddr;
    assign mem_wdata = memWdata;
    assign i_rdata   = iRdata;
    assign d_rdata   = dRdata;
    assign i_done    = iDone;
    assign d_done    = dDone;
    assign err       = errQ;
    assign i_stall   = i_req & ~iDone;
    assign d_stall   = d_req & ~dDone;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus hand-computed expectations for grant order, latency and held data.
module tb_mem_port_arbiter;
    localparam int MAXRUN = 4;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_done, i_stall, d_done, d_stall, mem_req, mem_we, err;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack   = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_RUN(MAXRUN), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    int nVec = 0, nBad = 0, cyc = 0;
    bit started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Memory: acks in the memLat-th BUSY cycle (0 = never); forceAck injects a stray ack.
    int memLat = 1, busyN = 0;
    bit forceAck = 0;
    function automatic logic [31:0] memFn(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2008_0005 : (a ^ 32'h5A5A_0000);
    endfunction
    always begin
        @(posedge clk);
        #2;
        busyN     = mem_req ? busyN + 1 : 0;
        mem_ack   = forceAck | (memLat != 0 && busyN == memLat);
        mem_rdata = memFn(mem_addr);
    end

    // Transaction-level model: which port owns the memory, for how many cycles, and what it returns.
    int          mBusy = 0, mAge = 0, mRun = 0, mSeq = 1;
    logic [31:0] mAddr = '0, mWd = '0, mIrd = '0, mDrd = '0;
    bit          mWe = 0, mIdone = 0, mDdone = 0, mErr = 0;
    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (!reset_n) begin
            mBusy = 0; mAge = 0; mRun = 0;
            mIrd = '0; mDrd = '0; mIdone = 0; mDdone = 0; mErr = 0;
        end else begin
            mIdone = 0; mDdone = 0; mErr = 0;
            if (mBusy == 0) begin
                mAge = 0;
                if (d_req && (!i_req || mRun < MAXRUN)) begin
                    mBusy = 2; mAddr = d_addr; mWe = d_we; mWd = d_wdata;
                    mRun = i_req ? ((mRun + 1 > MAXRUN) ? MAXRUN : mRun + 1) : 0;
                    mSeq = mSeq * 2 + 1;
                end else if (i_req) begin
                    mBusy = 1; mAddr = i_addr; mWe = 0; mWd = '0; mRun = 0;
                    mSeq = mSeq * 2;
                end
            end else begin
                mAge++;
                if (mem_ack) begin
                    if (mBusy == 1) begin mIdone = 1; mIrd = mem_rdata; end
                    else begin mDdone = 1; if (!mWe) mDrd = mem_rdata; end
                    mBusy = 0;
                end else if (mAge == TMO) begin
                    if (mBusy == 1) mIdone = 1; else mDdone = 1;
                    mErr = 1;
                    mBusy = 0;
                end
            end
        end
    end

    // Per-cycle compare, plus an independent grant-order log taken from the DUT's mem_req edges.
    int dSeq = 1, iDoneCnt = 0;
    bit prevReq = 0;
    always @(negedge clk) begin
        if (started) begin
            check("mem_req", mem_req, mBusy != 0);
            if (mBusy != 0) begin
                check("mem_we", mem_we, mWe);
                check("mem_addr", mem_addr, mAddr);
                check("mem_wdata", mem_wdata, mWd);
            end
            check("i_done", i_done, mIdone);
            check("d_done", d_done, mDdone);
            check("err", err, mErr);
            check("i_rdata", i_rdata, mIrd);
            check("d_rdata", d_rdata, mDrd);
            check("i_stall", i_stall, i_req & ~mIdone);
            check("d_stall", d_stall, d_req & ~mDdone);
            if (mem_req && !prevReq) dSeq = dSeq * 2 + ((mem_addr != 32'h40) ? 1 : 0);
            prevReq = mem_req;
            if (i_done) iDoneCnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic iAccess(input logic [31:0] a, input int bound, output int doneCyc);
        i_addr = a; i_req = 1; doneCyc = -1;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (i_done) begin doneCyc = cyc; break; end
        end
        i_req = 0;
        if (doneCyc < 0) check("i_done_bound", 0, 1);
    endtask

    task automatic dAccess(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input int bound, output int doneCyc);
        d_we = we; d_addr = a; d_wdata = wd; d_req = 1; doneCyc = -1;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (d_done) begin doneCyc = cyc; break; end
        end
        d_req = 0;
        if (doneCyc < 0) check("d_done_bound", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ic, dc, g;
        reset_n = 0; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;

        // 1: reset held two cycles, then idle
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_done_err", {i_done, d_done, err}, 0);
        reset_n = 1;
        repeat (3) tick();

        // 2: single fetch, ack in the 3rd BUSY cycle
        memLat = 3;
        iAccess(32'h40, 20, ic);
        check("fetch_rdata", i_rdata, 32'h2008_0005);
        check("fetch_no_dside", {d_done, d_rdata}, 0);
        tick();

        // 4: D held with I pending: D,D,D,D then I
        memLat = 1; mSeq = 1; dSeq = 1;
        d_we = 0; d_addr = 32'h200; d_req = 1;
        i_addr = 32'h40; i_req = 1; ic = -1;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (i_done) begin ic = cyc; break; end
        end
        i_req = 0; d_req = 0;
        if (ic < 0) check("starve_bound", 0, 1);
        check("starve_order_model", mSeq, 32'd62);
        check("starve_order_dut", dSeq, 32'd62);
        check("starve_d_rdata", d_rdata, 32'h5A5A_0200);
        tick();

        // 3: collision after the I grant cleared the run count: D store first, then I
        dSeq = 1;
        fork
            iAccess(32'h40, 30, ic);
            dAccess(1'b1, 32'h100, 32'hDEAD_BEEF, 30, dc);
        join
        check("collide_d_before_i", (dc >= 0 && dc < ic) ? 1 : 0, 1);
        check("collide_order_dut", dSeq, 32'd6);
        check("collide_store_keeps_rdata", d_rdata, 32'h5A5A_0200);
        tick();

        // 5: load with no ack: abort 16 cycles after grant, data held, next access normal
        memLat = 0; g = -1; dc = -1;
        d_we = 0; d_addr = 32'h300; d_req = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (mem_req && g < 0) g = cyc;
            if (d_done) begin dc = cyc; break; end
        end
        check("tmo_err_with_done", {d_done, err}, 2'b11);
        d_req = 0;
        check("tmo_latency", dc - g, TMO);
        check("tmo_rdata_held", d_rdata, 32'h5A5A_0200);
        memLat = 1;
        tick();
        dAccess(1'b0, 32'h300, 32'h0, 20, dc);
        check("post_tmo_rdata", d_rdata, 32'h5A5A_0300);
        tick();

        // 6: reset in the 2nd BUSY_I cycle abandons the fetch; a stray ack is ignored
        memLat = 0; ic = iDoneCnt;
        i_addr = 32'h80; i_req = 1;
        for (int k = 0; k < 5 && !mem_req; k++) tick();
        tick();
        reset_n = 0;
        tick();
        check("midrst_mem_req", mem_req, 0);
        reset_n = 1; i_req = 0;
        forceAck = 1;
        tick();
        forceAck = 0;
        repeat (3) tick();
        check("midrst_no_done", iDoneCnt, ic);
        check("midrst_idle", mem_req, 0);
        memLat = 1;
        iAccess(32'h44, 20, ic);
        check("post_rst_fetch", i_rdata, 32'h5A5A_0044);
        check("post_rst_d_rdata", d_rdata, 0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
